// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths, master FSM states and request record
//
// Purpose: common definitions for the APB master and anything that builds
//          requests for it (bench drivers, requester stages).
// Contents:
//   ADDR_WIDTH, DATA_WIDTH  APB address / data widths
//   apb_state_e             master FSM state encoding
//   apb_req_t               one request: direction, address, write data
package apb_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_master.sv
// rtl/apb_master.sv - valid/ready request stream to APB SETUP/ACCESS master
//
// Purpose: accepts one request at a time in IDLE, runs a single APB transfer
//          and returns exactly one response pulse, aborting with rsp_err when
//          the slave holds PREADY low for too long.
// Ports:
//   PCLK, PRESETn                      clock, asynchronous active-low reset
//   req_valid/req_ready                request handshake (ready only in IDLE)
//   req_write, req_addr, req_wdata     request payload
//   rsp_valid, rsp_rdata, rsp_err      one-cycle response, no backpressure
//   PADDR, PWRITE, PSEL, PENABLE,
//   PWDATA                             APB master outputs (registered)
//   PRDATA, PREADY                     APB slave returns (used in ACCESS only)
// Parameters:
//   TIMEOUT_CYCLES  wait cycles tolerated in ACCESS before abort, 0 = never
//   CNT_WIDTH       wait counter width, 2**CNT_WIDTH > TIMEOUT_CYCLES
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  apb_state_e           state;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 timeout_hit;

  // Gating with PRESETn keeps req_ready low while reset is held, even though
  // the state register already sits in IDLE.
  assign req_ready = (state == IDLE) && PRESETn;

  // The counter only reaches TIMEOUT_CYCLES after that many PREADY-low ACCESS
  // cycles; the abort is taken on the following low cycle.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWDATA    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          // PADDR/PWRITE/PWDATA keep their last values while idle.
          if (req_valid) begin
            PADDR    <= req_addr;
            PWRITE   <= req_write;
            PWDATA   <= req_wdata;
            PSEL     <= 1'b1;
            PENABLE  <= 1'b0;
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // PREADY takes priority over a coincident timeout.
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            state     <= IDLE;
          end else if (timeout_hit) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master
module tb_apb_master;
  import apb_pkg::*;

  localparam int TO       = 4;
  localparam int CW       = 3;
  localparam int STUCK    = 1000;

  logic                  PCLK = 1'b0;
  logic                  PRESETn = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic                  req_write = 1'b0;
  logic [ADDR_WIDTH-1:0] req_addr = '0;
  logic [DATA_WIDTH-1:0] req_wdata = '0;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic                  PSEL;
  logic                  PENABLE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA = '0;
  logic                  PREADY = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transfer from the requester's view. Called at a negedge with the DUT
  // idle; returns at the negedge of the response cycle. waits = number of
  // PREADY-low ACCESS cycles the slave inserts (STUCK = never ready).
  // Expected timing comes from the transfer rules: SETUP one cycle, then
  // min(waits, TO)+1 ACCESS cycles, abort when waits exceed TO.
  task automatic xfer(input apb_req_t r, input int waits,
                      input logic [DATA_WIDTH-1:0] rd, input bit hold_valid);
    bit timed_out;
    int n_access;
    logic [DATA_WIDTH-1:0] exp_rd;
    timed_out = (waits > TO);
    n_access  = timed_out ? TO + 1 : waits + 1;
    exp_rd    = (timed_out || r.write) ? '0 : rd;

    check("idle_req_ready", req_ready, 1);
    check("idle_psel", PSEL, 0);
    req_valid = 1'b1;
    req_write = r.write;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    @(negedge PCLK);
    // Request fields are scrambled from here on; the DUT must ignore them.
    req_valid = hold_valid;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    check("setup_psel", PSEL, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_paddr", PADDR, r.addr);
    check("setup_pwrite", PWRITE, r.write);
    check("setup_pwdata", PWDATA, r.wdata);
    check("setup_req_ready", req_ready, 0);
    @(negedge PCLK);
    for (int k = 0; k < n_access; k++) begin
      check("acc_psel", PSEL, 1);
      check("acc_penable", PENABLE, 1);
      check("acc_paddr", PADDR, r.addr);
      check("acc_pwrite", PWRITE, r.write);
      check("acc_pwdata", PWDATA, r.wdata);
      check("acc_rsp_valid", rsp_valid, 0);
      check("acc_req_ready", req_ready, 0);
      PREADY = (k == waits);
      PRDATA = (k == waits) ? rd : $urandom;
      req_addr = $urandom;
      @(negedge PCLK);
    end
    PREADY = 1'b0;
    PRDATA = $urandom;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, timed_out);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("end_psel", PSEL, 0);
    check("end_penable", PENABLE, 0);
    check("end_req_ready", req_ready, 1);
  endtask

  task automatic idle_cycle();
    @(negedge PCLK);
    check("idle_rsp_pulse_once", rsp_valid, 0);
    check("idle_psel_low", PSEL, 0);
    check("idle_penable_low", PENABLE, 0);
  endtask

  function automatic apb_req_t mk(input logic w, input logic [31:0] a, input logic [31:0] d);
    apb_req_t r;
    r.write = w;
    r.addr  = a;
    r.wdata = d;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    apb_req_t r;
    int w;
    bit hold;

    // Reset state
    #12;
    check("rst_req_ready", req_ready, 0);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Zero-wait write
    xfer(mk(1'b1, 32'h04, 32'hDEADBEEF), 0, 32'h0, 1'b0);
    idle_cycle();
    // Read with 3 wait states
    xfer(mk(1'b0, 32'h08, 32'h0), 3, 32'h12345678, 1'b0);
    idle_cycle();
    // Stuck slave -> timeout
    xfer(mk(1'b0, 32'h10, 32'h0), STUCK, 32'hAAAA5555, 1'b0);
    idle_cycle();
    // PREADY on the timeout cycle -> normal completion
    xfer(mk(1'b0, 32'h14, 32'h0), TO, 32'hCAFEF00D, 1'b0);
    idle_cycle();
    // Back-to-back writes with req_valid held
    xfer(mk(1'b1, 32'h20, 32'h11111111), 0, 32'h0, 1'b1);
    xfer(mk(1'b1, 32'h24, 32'h22222222), 0, 32'h0, 1'b1);
    xfer(mk(1'b1, 32'h28, 32'h33333333), 0, 32'h0, 1'b0);
    idle_cycle();

    // Reset during ACCESS
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h55AA55AA;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    PREADY = 1'b0;
    check("pre_rst_penable", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    check("midrst_psel", PSEL, 0);
    check("midrst_penable", PENABLE, 0);
    check("midrst_paddr", PADDR, 0);
    check("midrst_pwdata", PWDATA, 0);
    check("midrst_pwrite", PWRITE, 0);
    check("midrst_req_ready", req_ready, 0);
    repeat (2) begin
      @(negedge PCLK);
      check("midrst_no_rsp", rsp_valid, 0);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("post_rst_no_rsp", rsp_valid, 0);
    xfer(mk(1'b0, 32'h44, 32'h0), 1, 32'h0BADC0DE, 1'b0);
    idle_cycle();

    // Randomized traffic
    hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r = mk(1'($urandom), $urandom, $urandom);
      w = ($urandom_range(0, 5) == 0) ? STUCK : int'($urandom_range(0, TO + 1));
      hold = (i != 39) && ($urandom_range(0, 2) == 0);
      xfer(r, w, $urandom, hold);
      if (!hold) begin
        idle_cycle();
        repeat ($urandom_range(0, 2)) idle_cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
